// File: rtl/cordic_pkg.sv
// +--------------------------------------------------------------------+
// | cordic_pkg : shared widths, gain constant and phase-gen states      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cordic_pkg;
  localparam int          DATA_WIDTH_DEF  = 16;
  localparam int          ANGLE_WIDTH_DEF = 32;
  localparam int          ITER_DEF        = 16;
  localparam logic [15:0] KINV_Q15_DEF    = 16'd19898;
  localparam logic [31:0] PI_OVER_2       = 32'h4000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } phase_gen_state_e;
endpackage

`default_nettype wire

// File: rtl/valid_delay_line.sv
// +--------------------------------------------------------------------+
// | valid_delay_line : DEPTH-stage strobe delay matching rotator latency |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module valid_delay_line #(
  parameter int DEPTH = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_valid,
  output logic out_valid,
  output logic empty
);
  logic [DEPTH-1:0] vdly_q;
  logic [DEPTH-1:0] vdly_d;

  always_comb begin
    vdly_d = {vdly_q[DEPTH-2:0], in_valid};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vdly_q <= '0;
    else          vdly_q <= vdly_d;
  end

  assign out_valid = vdly_q[DEPTH-1];
  // After this edge nothing remains behind the output stage, so the
  // final pulse leaves on its own and the owner may stop waiting now.
  assign empty     = ~|vdly_d[DEPTH-2:0];
endmodule

`default_nettype wire

// File: rtl/cordic_phase_gen.sv
// +--------------------------------------------------------------------+
// | cordic_phase_gen : NCO + gain-precompensated feeder for sine_cosine |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module cordic_phase_gen
  import cordic_pkg::*;
#(
  parameter int          DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int          ANGLE_WIDTH = ANGLE_WIDTH_DEF,
  parameter int          ITER        = ITER_DEF,
  parameter logic [15:0] KINV_Q15    = KINV_Q15_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ANGLE_WIDTH-1:0] cfg_freq,
  input  logic [ANGLE_WIDTH-1:0] cfg_phase,
  input  logic [DATA_WIDTH-2:0]  cfg_amp,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic [DATA_WIDTH-1:0]  Xin,
  output logic [DATA_WIDTH-1:0]  Yin,
  output logic                   sample_valid,
  output logic                   out_valid,
  output logic                   busy
);
  localparam int PROD_W = DATA_WIDTH - 1 + 16;

  phase_gen_state_e       state_q, state_d;
  logic [ANGLE_WIDTH-1:0] phase_q, phase_d;
  logic [ANGLE_WIDTH-1:0] freq_q, freq_d;
  logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic [DATA_WIDTH-1:0]  xk_q, xk_d;
  logic [DATA_WIDTH-1:0]  xin_q, xin_d;
  logic                   sample_valid_q, sample_valid_d;
  logic [PROD_W-1:0]      amp_prod;
  logic                   cfg_fire;
  logic                   dly_empty;

  // amp * (1/K) in Q15; the shifted result is always below 2^(DATA_WIDTH-1)
  assign amp_prod = PROD_W'(cfg_amp) * PROD_W'(KINV_Q15);
  assign cfg_fire = cfg_valid && cfg_ready;

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    freq_d         = freq_q;
    xk_d           = xk_q;
    angle_d        = angle_q;
    xin_d          = xin_q;
    sample_valid_d = 1'b0;
    if (cfg_fire) begin
      freq_d = cfg_freq;
      xk_d   = DATA_WIDTH'(amp_prod >> 15);
    end
    case (state_q)
      IDLE: begin
        if (cfg_fire) phase_d = cfg_phase;
        if (start)    state_d = RUN;
      end
      RUN: begin
        angle_d        = phase_q;
        xin_d          = xk_q;
        sample_valid_d = 1'b1;
        phase_d        = phase_q + freq_q;
        if (stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (dly_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      freq_q         <= '0;
      xk_q           <= '0;
      angle_q        <= '0;
      xin_q          <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      freq_q         <= freq_d;
      xk_q           <= xk_d;
      angle_q        <= angle_d;
      xin_q          <= xin_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  valid_delay_line #(
    .DEPTH (ITER)
  ) u_vdly (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (sample_valid_q),
    .out_valid (out_valid),
    .empty     (dly_empty)
  );

  assign cfg_ready    = (state_q != DRAIN);
  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign angle        = angle_q;
  assign Xin          = xin_q;
  assign Yin          = '0;
  assign sample_valid = sample_valid_q;
endmodule

`default_nettype wire

// File: doc/cordic_phase_gen.md
# cordic_phase_gen

Upstream feeder for the `sine_cosine` CORDIC rotator.
- Runs a programmable phase accumulator (NCO) that presents one signed angle per clock while running.
- Drives gain-precompensated `Xin`/`Yin` so the rotator's `Xout`/`Yout` come out at the programmed amplitude.
- Delays its own sample strobe by the rotator's latency, giving downstream logic an `out_valid` aligned with the rotator outputs.
- Provides a start/stop/drain control machine and a config handshake for frequency, start phase and amplitude.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of `Xin`/`Yin`; must match the rotator.
- `ANGLE_WIDTH`, 32: angle width. Full circle 2π = 2^ANGLE_WIDTH; signed two's complement, so the range is −π…+π.
- `ITER`, 16: rotator latency in clocks, from the edge that registers `angle`/`Xin` to `Xout`/`Yout` valid.
- `KINV_Q15`, 19898: 1/K CORDIC gain compensation, unsigned Q15 (≈0.60724).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled. Leaves IDLE.
- `stop`  in  1  level-sampled. Leaves RUN.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config accept (combinational from state).
- `cfg_freq`  in  ANGLE_WIDTH  unsigned phase increment per sample.
- `cfg_phase`  in  ANGLE_WIDTH  start phase. Used only when accepted in IDLE.
- `cfg_amp`  in  DATA_WIDTH-1  unsigned amplitude.
- `angle`  out  ANGLE_WIDTH  signed angle to the rotator.
- `Xin`  out  DATA_WIDTH  signed, = (`amp` × `KINV_Q15`) >> 15.
- `Yin`  out  DATA_WIDTH  constant 0.
- `sample_valid`  out  1  `angle`/`Xin` hold a new sample this cycle.
- `out_valid`  out  1  rotator `Xout`/`Yout` valid this cycle.
- `busy`  out  1  high in RUN or DRAIN.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`. `stop` is ignored in IDLE.
  - RUN→DRAIN on `stop`. `start` is ignored in RUN.
  - DRAIN→IDLE when the valid delay line is empty. `start` and `stop` are ignored in DRAIN.
- Registers:
  - `phase_r`, `freq_r`: ANGLE_WIDTH.
  - `xk_r`: DATA_WIDTH. Holds the scaled amplitude.
  - `vdly`: ITER bits.
- Config handshake:
  - `cfg_ready` = (state != DRAIN). A transfer happens when `cfg_valid && cfg_ready` at an edge.
  - Accepted in IDLE: loads `freq_r`, `phase_r ← cfg_phase`, and `xk_r`.
  - Accepted in RUN: loads `freq_r` and `xk_r`; `cfg_phase` is ignored.
- Amplitude scaling:
  - One DATA_WIDTH-1 × 16 unsigned multiply, shifted right by 15, truncated, zero-extended to DATA_WIDTH.
  - The result is always positive and below 2^(DATA_WIDTH-1), so the rotator output cannot overflow.
- RUN, every edge:
  - `angle ← phase_r`, `Xin ← xk_r`, `sample_valid ← 1`.
  - `phase_r ← phase_r + freq_r`, mod 2^ANGLE_WIDTH. Wraps silently from +π to −π.
- Outside RUN:
  - `sample_valid ← 0`.
  - `angle` and `Xin` hold their last values.
  - `phase_r` holds.
- `vdly` shifts `sample_valid` in every edge, in every state. `out_valid` = `vdly[ITER-1]`.
- Reset (`reset_n` low, any time, including mid-RUN):
  - State goes to IDLE.
  - All registers and outputs go to 0: `angle`, `Xin`, `Yin`, `sample_valid`, `out_valid`, `busy`, `freq_r`, `phase_r`, `xk_r`, `vdly`.
  - `cfg_ready` = 1 once in IDLE.
  - Any in-flight rotator samples are never flagged valid.

## Timing
- The start edge (IDLE→RUN) emits no sample. The first sample registers on the next edge with `angle` = start phase.
- RUN emits one sample per clock, with no bubbles.
- `out_valid` rises exactly ITER cycles after the matching `sample_valid`.
- Config accepted at edge k while in RUN:
  - The sample at edge k+1 uses the new `Xin`.
  - The angle step between the samples at edges k+1 and k+2 is the new `freq_r`.
- `stop` sampled at edge s:
  - The last sample is emitted at edge s.
  - DRAIN lasts until `vdly` is all-zero; IDLE is entered ITER edges after s.
  - `busy` falls together with the entry to IDLE.
- Simultaneous `stop` + `cfg_valid` in RUN: the config is accepted and the state still goes to DRAIN.

## Structure
- Shared package `cordic_pkg`: ANGLE_WIDTH/DATA_WIDTH defaults, `KINV_Q15`, the PI_OVER_2 constant, and the state enum {IDLE, RUN, DRAIN}.
- Sub-module `valid_delay_line` (parameter DEPTH = ITER): shift register with async active-low reset, plus an `empty` flag used by the DRAIN exit.
- Top-level integration instantiates this block and `sine_cosine` side by side on the same `clock`.

## Test plan
- Reset mid-RUN with 5 samples in flight → all outputs are 0 the same cycle and `out_valid` never asserts for those samples.
- Config `freq`=0x0800_0000, `phase`=0, `amp`=0x7FFF, then `start` → `angle` sequence 0, 0x0800_0000, 0x1000_0000, …; `Xin`=0x4DB9; `out_valid` first high ITER cycles after the first `sample_valid`.
- `freq`=0x4000_0000, `phase`=0x4000_0000 → `angle` sequence 0x4000_0000, 0x8000_0000 (−π), 0xC000_0000, 0x0000_0000; wrap with no glitch in `sample_valid`.
- Mid-RUN config `freq` 0x100→0x300 accepted at edge k → angle step is 0x100 up to edge k+1 and 0x300 from edge k+2 on.
- `stop` at edge s → `cfg_ready` low during DRAIN, exactly ITER `out_valid` pulses remain, then IDLE with `busy`=0; `start` pulsed during DRAIN is ignored.
- Golden check through `sine_cosine` with `amp`=16384 → |Xout|, |Yout| within ±4 LSB of 16384·cos/sin(angle) for 1000 random phases.
